// File: rtl/d3s_lut_pkg.sv
// ============================================================================
// Module  : d3s_lut_pkg
// Brief   : Shared types and address layout for the D3S ping-pong LUT banks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package d3s_lut_pkg;

    localparam int LUT_SAMPLE_BITS = 18;
    localparam int LUT_SLOPE_BITS  = 18;
    localparam int LUT_ENTRY_BITS  = LUT_SAMPLE_BITS + LUT_SLOPE_BITS;

    // RAM address is {bank, lut_sel, entry}; positions counted from the MSB so
    // the LUT stage decodes the same layout for any LUT depth.
    localparam int LUT_ADDR_CTRL_BITS     = 2;
    localparam int LUT_ADDR_BANK_FROM_MSB = 0;
    localparam int LUT_ADDR_SEL_FROM_MSB  = 1;

    typedef struct packed {
        logic [LUT_SAMPLE_BITS-1:0] sample;
        logic [LUT_SLOPE_BITS-1:0]  slope;
    } lut_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_SWAP_WAIT = 2'd2,
        ST_SWAP_DO   = 2'd3
    } lut_state_e;

endpackage

`default_nettype wire

// File: rtl/d3s_lut_bank_ctrl_swap_timer.sv
// ============================================================================
// Module  : d3s_swap_timer
// Brief   : Bounded wait for a phase wrap; expires after 2^N-1 running cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module d3s_swap_timer #(
    parameter int g_swap_timeout_log2 = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic run_i,
    output logic expire_o
);

    logic [g_swap_timeout_log2-1:0] cnt_q;
    logic [g_swap_timeout_log2-1:0] cnt_d;
    logic                           at_limit;

    assign at_limit = &cnt_q;
    assign expire_o = run_i & at_limit;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (run_i && !at_limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/d3s_lut_bank_ctrl.sv
// ============================================================================
// Module  : d3s_lut_bank_ctrl
// Brief   : Ping-pong LUT bank controller: shadow-bank writes/fills and
//           wrap-aligned bank swaps for the D3S DAC datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module d3s_lut_bank_ctrl
    import d3s_lut_pkg::*;
#(
    parameter int g_lut_size_log2     = 10,
    parameter int g_entry_bits        = LUT_ENTRY_BITS,
    parameter int g_swap_timeout_log2 = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       host_wr_i,
    input  logic                       host_lut_sel_i,
    input  logic [g_lut_size_log2-1:0] host_addr_i,
    input  logic [g_entry_bits-1:0]    host_data_i,
    output logic                       host_ready_o,
    input  logic                       fill_req_i,
    input  logic [g_entry_bits-1:0]    fill_data_i,
    input  logic                       swap_req_i,
    input  logic                       phase_valid_i,
    input  logic                       phase_wrap_i,
    output logic                       ram_we_o,
    output logic [g_lut_size_log2+1:0] ram_addr_o,
    output logic [g_entry_bits-1:0]    ram_data_o,
    output logic                       active_bank_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       swap_forced_o,
    output logic                       err_drop_o
);

    localparam int ADDR_W = g_lut_size_log2 + LUT_ADDR_CTRL_BITS;
    localparam int CNT_W  = g_lut_size_log2 + 1;

    lut_state_e              state_q, state_d;
    logic [CNT_W-1:0]        fill_cnt_q, fill_cnt_d;
    logic [g_entry_bits-1:0] fill_data_q, fill_data_d;
    logic                    wr_we_q, wr_we_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [g_entry_bits-1:0] wr_data_q, wr_data_d;
    logic                    bank_q, bank_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;
    logic                    forced_q, forced_d;
    logic                    drop_q, drop_d;
    logic                    timer_start;
    logic                    timer_run;
    logic                    timer_expire;
    logic                    fill_active;

    d3s_swap_timer #(
        .g_swap_timeout_log2 (g_swap_timeout_log2)
    ) u_swap_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (timer_start),
        .run_i    (timer_run),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        fill_data_d = fill_data_q;
        wr_we_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        bank_d      = bank_q;
        done_d      = 1'b0;
        forced_d    = forced_q;
        drop_d      = 1'b0;
        timer_start = 1'b0;
        timer_run   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ready_q is low for the first cycle after reset release
                if (ready_q) begin
                    if (fill_req_i) begin
                        state_d     = ST_FILL;
                        fill_cnt_d  = '0;
                        fill_data_d = fill_data_i;
                        drop_d      = swap_req_i | host_wr_i;
                    end else if (swap_req_i) begin
                        state_d     = ST_SWAP_WAIT;
                        timer_start = 1'b1;
                        forced_d    = 1'b0;
                        drop_d      = host_wr_i;
                    end else if (host_wr_i) begin
                        wr_we_d   = 1'b1;
                        wr_addr_d = {~bank_q, host_lut_sel_i, host_addr_i};
                        wr_data_d = host_data_i;
                    end
                end
            end
            ST_FILL: begin
                if (&fill_cnt_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            ST_SWAP_WAIT: begin
                timer_run = 1'b1;
                // A wrap on the expiry cycle still counts as a natural swap
                if (phase_valid_i && phase_wrap_i) begin
                    state_d = ST_SWAP_DO;
                end else if (timer_expire) begin
                    state_d  = ST_SWAP_DO;
                    forced_d = 1'b1;
                end
            end
            ST_SWAP_DO: begin
                bank_d  = ~bank_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            fill_cnt_q  <= '0;
            fill_data_q <= '0;
            wr_we_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            bank_q      <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            forced_q    <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_data_q <= fill_data_d;
            wr_we_q     <= wr_we_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            bank_q      <= bank_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            forced_q    <= forced_d;
            drop_q      <= drop_d;
        end
    end

    // Fill writes come straight from the counter so the first one lands the
    // cycle after acceptance; host writes never overlap a fill.
    assign fill_active   = (state_q == ST_FILL);
    assign ram_we_o      = wr_we_q | fill_active;
    assign ram_addr_o    = fill_active ? {~bank_q, fill_cnt_q} : wr_addr_q;
    assign ram_data_o    = fill_active ? fill_data_q : wr_data_q;
    assign host_ready_o  = ready_q;
    assign active_bank_o = bank_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign swap_forced_o = forced_q;
    assign err_drop_o    = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_d3s_lut_bank_ctrl.sv
// ============================================================================
// Module  : tb_d3s_lut_bank_ctrl
// Brief   : Scoreboard bench for d3s_lut_bank_ctrl with randomized traffic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d3s_lut_bank_ctrl;

    localparam int LS   = 4;
    localparam int EB   = 36;
    localparam int TO   = 7;
    localparam int NWR  = 2 * (1 << LS);
    localparam int TMAX = 1 << TO;

    typedef struct packed {
        logic [LS+1:0] addr;
        logic [EB-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_wr = 1'b0;
    logic          host_lut_sel = 1'b0;
    logic [LS-1:0] host_addr = '0;
    logic [EB-1:0] host_data = '0;
    logic          fill_req = 1'b0;
    logic [EB-1:0] fill_data = '0;
    logic          swap_req = 1'b0;
    logic          phase_valid = 1'b0;
    logic          phase_wrap = 1'b0;
    logic          host_ready_o, ram_we_o, active_bank_o, busy_o;
    logic          done_o, swap_forced_o, err_drop_o;
    logic [LS+1:0] ram_addr_o;
    logic [EB-1:0] ram_data_o;

    int   checks = 0;
    int   failures = 0;
    int   exp_drops = 0;
    logic model_bank = 1'b0;
    wr_t  exp_q[$];

    d3s_lut_bank_ctrl #(
        .g_lut_size_log2     (LS),
        .g_entry_bits        (EB),
        .g_swap_timeout_log2 (TO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .host_wr_i      (host_wr),
        .host_lut_sel_i (host_lut_sel),
        .host_addr_i    (host_addr),
        .host_data_i    (host_data),
        .host_ready_o   (host_ready_o),
        .fill_req_i     (fill_req),
        .fill_data_i    (fill_data),
        .swap_req_i     (swap_req),
        .phase_valid_i  (phase_valid),
        .phase_wrap_i   (phase_wrap),
        .ram_we_o       (ram_we_o),
        .ram_addr_o     (ram_addr_o),
        .ram_data_o     (ram_data_o),
        .active_bank_o  (active_bank_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .swap_forced_o  (swap_forced_o),
        .err_drop_o     (err_drop_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_phase(input bit qual);
        if (qual) begin
            phase_valid = 1'b1;
            phase_wrap  = 1'b1;
        end else begin
            case ($urandom % 4)
                0:       begin phase_valid = 1'b1; phase_wrap = 1'b0; end
                1:       begin phase_valid = 1'b0; phase_wrap = 1'b1; end
                default: begin phase_valid = 1'b0; phase_wrap = 1'b0; end
            endcase
        end
    endtask

    task automatic clear_req();
        host_wr = 1'b0; swap_req = 1'b0; fill_req = 1'b0;
        phase_valid = 1'b0; phase_wrap = 1'b0;
    endtask

    task automatic wr_one(input logic sel, input logic [LS-1:0] a, input logic [EB-1:0] d);
        wr_t w;
        host_wr = 1'b1; host_lut_sel = sel; host_addr = a; host_data = d;
        w.addr = {~model_bank, sel, a};
        w.data = d;
        exp_q.push_back(w);
        tick();
        host_wr = 1'b0;
    endtask

    task automatic wr_burst(input int n);
        chk("ready_before_wr", host_ready_o, 1);
        for (int i = 0; i < n; i++) begin
            wr_one(1'($urandom), LS'($urandom), EB'({$urandom, $urandom}));
        end
    endtask

    // Drop test flags add a same-cycle lower-priority request.
    task automatic do_fill(input logic [EB-1:0] d, input logic with_swap, input logic with_wr);
        wr_t w;
        chk("ready_before_fill", host_ready_o, 1);
        fill_req = 1'b1; fill_data = d; swap_req = with_swap; host_wr = with_wr;
        host_lut_sel = 1'($urandom); host_addr = LS'($urandom);
        if (with_swap || with_wr) exp_drops++;
        for (int i = 0; i < NWR; i++) begin
            w.addr = {~model_bank, (LS+1)'(i)};
            w.data = d;
            exp_q.push_back(w);
        end
        tick();
        clear_req();
        fill_data = EB'({$urandom, $urandom});
        chk("fill_busy", busy_o, 1);
        for (int j = 1; j <= NWR; j++) begin
            host_wr = 1'($urandom); swap_req = 1'($urandom); fill_req = 1'($urandom);
            chk("fill_we", ram_we_o, 1);
            chk("fill_ready_low", host_ready_o, 0);
            tick();
        end
        clear_req();
        chk("fill_done", done_o, 1);
        chk("fill_busy_end", busy_o, 0);
        chk("fill_ready_end", host_ready_o, 1);
        chk("fill_bank", active_bank_o, model_bank);
    endtask

    // Wrap qualifies when driven in wait cycle k, 1..TMAX; otherwise timeout.
    task automatic do_swap(input int k, input logic with_wr);
        int   e;
        logic exp_forced;
        logic old;
        chk("ready_before_swap", host_ready_o, 1);
        old        = model_bank;
        exp_forced = !(k >= 1 && k <= TMAX);
        e          = exp_forced ? TMAX + 2 : k + 2;
        swap_req = 1'b1; host_wr = with_wr;
        if (with_wr) exp_drops++;
        drive_phase(k == 0);
        tick();
        swap_req = 1'b0;
        for (int j = 1; j < e; j++) begin
            chk("swap_bank_hold", active_bank_o, old);
            chk("swap_done_low", done_o, 0);
            if (j == 1) chk("swap_forced_cleared", swap_forced_o, 0);
            host_wr = 1'($urandom);
            drive_phase(j == k);
            tick();
        end
        clear_req();
        model_bank = ~old;
        chk("swap_bank_new", active_bank_o, model_bank);
        chk("swap_done", done_o, 1);
        chk("swap_forced", swap_forced_o, exp_forced);
        chk("swap_busy_end", busy_o, 0);
        chk("swap_ready_end", host_ready_o, 1);
    endtask

    task automatic reset_mid_fill();
        wr_t w;
        fill_req = 1'b1; fill_data = EB'({$urandom, $urandom});
        for (int i = 0; i < 10; i++) begin
            w.addr = {~model_bank, (LS+1)'(i)};
            w.data = fill_data;
            exp_q.push_back(w);
        end
        tick();
        fill_req = 1'b0;
        for (int j = 1; j <= 10; j++) tick();
        #1 rst = 1'b1;
        #1;
        model_bank = 1'b0;
        chk("rst_we", ram_we_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_bank", active_bank_o, 0);
        chk("rst_ready", host_ready_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_ready_after", host_ready_o, 1);
    endtask

    // Scoreboard monitor: every write and drop pulse must be expected.
    always @(negedge clk) begin
        wr_t w;
        if (!rst) begin
            if (ram_we_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", ram_addr_o, ram_data_o);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", ram_addr_o, w.addr);
                    chk("wr_data", ram_data_o, w.data);
                end
            end
            if (err_drop_o) begin
                checks++;
                if (exp_drops == 0) begin
                    failures++;
                    $display("FAIL unexpected_drop: got err_drop=1 expected 0 at %0t", $time);
                end else begin
                    exp_drops--;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("reset_ready", host_ready_o, 0);
        chk("reset_we", ram_we_o, 0);
        chk("reset_bank", active_bank_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_forced", swap_forced_o, 0);
        chk("reset_drop", err_drop_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", host_ready_o, 1);

        wr_one(1'b1, 4'd5, 36'h123456789);
        wr_burst(20);
        do_fill(36'hA5, 1'b0, 1'b0);
        do_swap(100, 1'b0);
        wr_burst(3);
        do_swap(TMAX + 50, 1'b0);
        do_swap(int'($urandom_range(1, TMAX)), 1'b0);
        do_swap(TMAX, 1'b0);
        do_swap(0, 1'b0);
        do_swap(1, 1'b1);
        do_fill(EB'({$urandom, $urandom}), 1'b1, 1'b1);
        do_fill(EB'({$urandom, $urandom}), 1'b0, 1'b1);

        for (int it = 0; it < 12; it++) begin
            case ($urandom % 3)
                0:       wr_burst(int'($urandom_range(1, 8)));
                1:       do_fill(EB'({$urandom, $urandom}), 1'($urandom), 1'($urandom));
                default: do_swap(int'($urandom_range(0, TMAX + 3)), 1'($urandom));
            endcase
        end

        if (model_bank == 1'b0) do_swap(5, 1'b0);
        reset_mid_fill();
        wr_burst(4);

        repeat (4) tick();
        chk("writes_pending", exp_q.size(), 0);
        chk("drops_pending", exp_drops, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
